// File: rtl/laser_pkg.sv
// Shared definitions for the multi-lane laser receiver.
// Optional feature macro: LASER_RX_PARITY_EN (adds the PARITY lane state).
package laser_pkg;

    localparam logic START_LEVEL = 1'b1;
    localparam logic STOP_LEVEL  = 1'b0;

`ifdef LASER_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } lane_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } lane_state_e;
`endif

endpackage

// File: rtl/laser_lane_rx.sv
// Single laser lane: 2-flop synchroniser, framing FSM, bit counters and
// LSB-first shift register. Result pulses are registered, so they appear
// the cycle after the stop-bit sample.
// Optional feature macro: LASER_RX_PARITY_EN (even parity bit before stop).
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | counters cleared, waiting for a synchronised high
// START  | mid-start-bit check; a low here is a glitch, back to IDLE
// DATA   | sample one data bit per bit period, LSB first
// PARITY | sample the even-parity bit (parity build only)
// STOP   | sample stop bit, report word / frame / parity result
module laser_lane_rx
    import laser_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              laser_in,
    output logic              lane_done,
    output logic [DATA_W-1:0] word,
    output logic              frame_error,
    output logic              parity_error
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) >> 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    logic              sync1, sync2;
    lane_state_e       state, state_n;
    logic [CW-1:0]     clk_cnt, clk_cnt_n;
    logic [BW-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic              done_n, ferr_n;
`ifdef LASER_RX_PARITY_EN
    logic              par_bad, par_bad_n;
    logic              perr_n;
`endif

    assign word = shift;

    // Next-state, counter and result-pulse logic for one lane.
    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        done_n    = 1'b0;
        ferr_n    = 1'b0;
`ifdef LASER_RX_PARITY_EN
        par_bad_n = par_bad;
        perr_n    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                clk_cnt_n = '0;
                bit_cnt_n = '0;
`ifdef LASER_RX_PARITY_EN
                par_bad_n = 1'b0;
`endif
                if (sync2 == START_LEVEL) begin
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (clk_cnt == CNT_HALF) begin
                    clk_cnt_n = '0;
                    state_n   = (sync2 == START_LEVEL) ? ST_DATA : ST_IDLE;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_n = '0;
                    // shift in at the MSB so the first bit ends up at bit 0
                    shift_n   = (shift >> 1) | (DATA_W'(sync2) << (DATA_W - 1));
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
`ifdef LASER_RX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
`ifdef LASER_RX_PARITY_EN
            ST_PARITY: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_n = '0;
                    par_bad_n = (sync2 != ^shift);
                    state_n   = ST_STOP;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_n = '0;
                    state_n   = ST_IDLE;
                    if (sync2 != STOP_LEVEL) begin
                        ferr_n = 1'b1;
`ifdef LASER_RX_PARITY_EN
                    end else if (par_bad) begin
                        perr_n = 1'b1;
`endif
                    end else begin
                        done_n = 1'b1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // disable drops any frame in progress silently
        if (!en) begin
            state_n   = ST_IDLE;
            clk_cnt_n = '0;
            bit_cnt_n = '0;
            done_n    = 1'b0;
            ferr_n    = 1'b0;
`ifdef LASER_RX_PARITY_EN
            perr_n    = 1'b0;
`endif
        end
    end

    // Synchroniser, state and counter registers, registered result pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            state       <= ST_IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            lane_done   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            sync1       <= laser_in;
            sync2       <= sync1;
            state       <= state_n;
            clk_cnt     <= clk_cnt_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            lane_done   <= done_n;
            frame_error <= ferr_n;
        end
    end

`ifdef LASER_RX_PARITY_EN
    // Parity result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            par_bad      <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            par_bad      <= par_bad_n;
            parity_error <= perr_n;
        end
    end
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: rtl/laser_multilane_rx.sv
// Multi-lane laser receiver: LANES independent lane deserialisers feeding
// a group aligner that emits one LANES*DATA_W word per complete group and
// flags groups dropped on skew timeout or lane overrun.
// Optional feature macro: LASER_RX_PARITY_EN (per-lane even parity check).
module laser_multilane_rx
    import laser_pkg::*;
#(
    parameter int LANES        = 2,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 8,
    parameter int SKEW_MAX     = 4 * CLKS_PER_BIT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic [LANES-1:0]        laser_in,
    output logic                    data_valid,
    output logic [LANES*DATA_W-1:0] data_out,
    output logic [LANES-1:0]        frame_error,
    output logic [LANES-1:0]        parity_error,
    output logic                    skew_error
);

    localparam int SW = $clog2(SKEW_MAX + 1);
    localparam logic [SW-1:0] SKEW_LIMIT = SW'(SKEW_MAX);

    logic [LANES-1:0]             lane_done;
    logic [LANES-1:0][DATA_W-1:0] lane_word;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        laser_lane_rx #(
            .DATA_W       (DATA_W),
            .CLKS_PER_BIT (CLKS_PER_BIT)
        ) u_lane (
            .clock        (clock),
            .reset        (reset),
            .en           (en),
            .laser_in     (laser_in[g]),
            .lane_done    (lane_done[g]),
            .word         (lane_word[g]),
            .frame_error  (frame_error[g]),
            .parity_error (parity_error[g])
        );
    end

    logic [LANES-1:0]             flags, flags_n, merged;
    logic [LANES-1:0][DATA_W-1:0] hold, hold_n;
    logic [SW-1:0]                skew_cnt, skew_cnt_n;
    logic                         skew_run, skew_run_n;
    logic                         dv_n, sk_n;
    logic [LANES*DATA_W-1:0]      data_out_n;
    logic                         overrun, complete, timeout;

    // Group aligner: merge arriving words, detect completion, overrun, timeout.
    always_comb begin
        overrun  = |(lane_done & flags);
        // an overrun drops the old group; arriving words seed the new one
        merged   = overrun ? lane_done : (flags | lane_done);
        complete = &merged;
        timeout  = skew_run && (skew_cnt == SKEW_LIMIT);

        for (int i = 0; i < LANES; i++) begin
            hold_n[i] = lane_done[i] ? lane_word[i] : hold[i];
        end

        flags_n    = flags;
        skew_cnt_n = skew_cnt;
        skew_run_n = skew_run;
        dv_n       = 1'b0;
        sk_n       = 1'b0;
        data_out_n = data_out;

        if (complete) begin
            // completion beats a coincident timeout
            dv_n       = 1'b1;
            sk_n       = overrun;
            data_out_n = hold_n;
            flags_n    = '0;
            skew_run_n = 1'b0;
            skew_cnt_n = '0;
        end else if (overrun || timeout) begin
            sk_n       = 1'b1;
            flags_n    = lane_done;
            skew_run_n = |lane_done;
            skew_cnt_n = '0;
        end else begin
            flags_n = merged;
            if (!skew_run && (|lane_done)) begin
                skew_run_n = 1'b1;
                skew_cnt_n = '0;
            end else if (skew_run) begin
                skew_cnt_n = skew_cnt + 1'b1;
            end
        end

        if (!en) begin
            flags_n    = '0;
            skew_run_n = 1'b0;
            skew_cnt_n = '0;
            dv_n       = 1'b0;
            sk_n       = 1'b0;
            data_out_n = data_out;
        end
    end

    // Aligner registers and output pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            flags      <= '0;
            hold       <= '0;
            skew_cnt   <= '0;
            skew_run   <= 1'b0;
            data_valid <= 1'b0;
            skew_error <= 1'b0;
            data_out   <= '0;
        end else begin
            flags      <= flags_n;
            hold       <= hold_n;
            skew_cnt   <= skew_cnt_n;
            skew_run   <= skew_run_n;
            data_valid <= dv_n;
            skew_error <= sk_n;
            data_out   <= data_out_n;
        end
    end

endmodule
